mem16_arbiter: RTL and testbench

- Shares the single 16-bit word memory (11-bit word address, 16-bit data, byte-split posedge/negedge write and read) between two requesters.
  - Port F: instruction fetch, read-only.
  - Port D: data load/store.
- Arbitrates between the ports, drives the memory's address/data/write-enable, and holds them stable for a fixed access window.
- Captures read data and returns a one-cycle acknowledge.
- Sits between the CPU control unit and the memory in the processor top level.

---
 rtl/mem16_arbiter_pkg.sv | 24 ++
 rtl/mem16_arbiter_priority.sv | 19 +
 rtl/mem16_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem16_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem16_arbiter_pkg.sv
// Shared types and helpers for the two-port 16-bit word memory arbiter.
package mem16_arbiter_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == STAT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem16_arbiter_priority.sv
// Combinational winner select: D by default, F once D has won STARVE_LIMIT times over a waiting F.
module mem16_arb_priority #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned SW           = 3
) (
  input  logic          f_req,
  input  logic          d_req,
  input  logic [SW-1:0] starve_cnt,
  output logic          grant_d
);

  always_comb begin
    grant_d = 1'b0;
    if (d_req) begin
      grant_d = !(f_req && (starve_cnt == SW'(STARVE_LIMIT)));
    end
  end

endmodule

// File: rtl/mem16_arbiter.sv
// Arbitrates fetch (F) and data (D) ports onto the single 16-bit word memory.
// Define MEM16_ARB_STATS_EN to add saturating grant/stall statistic outputs.
module mem16_arbiter
  import mem16_arbiter_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_dataout
`ifdef MEM16_ARB_STATS_EN
  ,
  output logic [15:0]       stat_f_grants,
  output logic [15:0]       stat_d_grants,
  output logic [15:0]       stat_stall
`endif
);

  localparam int unsigned   CW         = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int unsigned   SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD   = CW'(ACCESS_CYCLES - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t        state;
  port_t         cur_port;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve_cnt;
  logic          grant_d;
  logic          any_req;

  assign any_req = f_req | d_req;

  mem16_arb_priority #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .SW           (SW)
  ) u_priority (
    .f_req      (f_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt),
    .grant_d    (grant_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      cur_port         <= PORT_F;
      cnt              <= '0;
      starve_cnt       <= '0;
      f_ack            <= 1'b0;
      d_ack            <= 1'b0;
      f_rdata          <= '0;
      d_rdata          <= '0;
      mem_address      <= '0;
      mem_datain       <= '0;
      mem_write_enable <= 1'b0;
    end else begin
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          mem_write_enable <= 1'b0;
          if (any_req) begin
            cnt   <= CNT_LOAD;
            state <= ST_ACCESS;
            if (grant_d) begin
              cur_port         <= PORT_D;
              mem_address      <= d_addr;
              mem_datain       <= d_wdata;
              mem_write_enable <= d_we;
              if (f_req && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
            end else begin
              cur_port    <= PORT_F;
              mem_address <= f_addr;
              starve_cnt  <= '0;
            end
          end
        end

        ST_ACCESS: begin
          if (cnt == '0) begin
            // Still-high write enable marks a store: d_rdata keeps the last load.
            if (cur_port == PORT_F) begin
              f_rdata <= mem_dataout;
              f_ack   <= 1'b1;
            end else begin
              if (!mem_write_enable) begin
                d_rdata <= mem_dataout;
              end
              d_ack <= 1'b1;
            end
            mem_write_enable <= 1'b0;
            state            <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state            <= ST_IDLE;
          mem_write_enable <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM16_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_f_grants <= '0;
      stat_d_grants <= '0;
      stat_stall    <= '0;
    end else begin
      if ((state == ST_IDLE) && any_req) begin
        if (grant_d) begin
          stat_d_grants <= sat_inc(stat_d_grants);
        end else begin
          stat_f_grants <= sat_inc(stat_f_grants);
        end
      end
      if ((f_req && !f_ack) || (d_req && !d_ack)) begin
        stat_stall <= sat_inc(stat_stall);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem16_arbiter.sv
// Self-checking bench for mem16_arbiter: vector table, corner sequences, randomized transactions.
// Covers the MEM16_ARB_STATS_EN counters when that macro is defined.
module tb_mem16_arbiter;

  localparam int AC  = 2;
  localparam int SL  = 4;
  localparam int AC1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        f_req, d_req, d_we, f_ack, d_ack, mem_write_enable;
  logic [10:0] f_addr, d_addr, mem_address;
  logic [15:0] d_wdata, f_rdata, d_rdata, mem_datain, mem_dataout;
`ifdef MEM16_ARB_STATS_EN
  logic [15:0] stat_f_grants, stat_d_grants, stat_stall;
`endif

  logic        f_req1, d_req1, d_we1, f_ack1, d_ack1, mem_write_enable1;
  logic [10:0] f_addr1, d_addr1, mem_address1;
  logic [15:0] d_wdata1, f_rdata1, d_rdata1, mem_datain1, mem_dataout1;

  function automatic logic [15:0] init_val(input logic [10:0] a);
    return 16'h8001 + ({5'd0, a} * 16'h0101);
  endfunction

  // Memory devices: unwritten words read as init_val(address).
  logic [15:0] mem0 [2048];
  bit          wr0  [2048];
  logic [15:0] mem1 [2048];
  bit          wr1  [2048];
  assign mem_dataout  = wr0[mem_address]  ? mem0[mem_address]  : init_val(mem_address);
  assign mem_dataout1 = wr1[mem_address1] ? mem1[mem_address1] : init_val(mem_address1);
  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem0[mem_address] <= mem_datain;
      wr0[mem_address]  <= 1'b1;
    end
    if (mem_write_enable1) begin
      mem1[mem_address1] <= mem_datain1;
      wr1[mem_address1]  <= 1'b1;
    end
  end

  mem16_arbiter #(.ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_datain(mem_datain),
    .mem_write_enable(mem_write_enable), .mem_dataout(mem_dataout)
`ifdef MEM16_ARB_STATS_EN
    , .stat_f_grants(stat_f_grants), .stat_d_grants(stat_d_grants), .stat_stall(stat_stall)
`endif
  );

  mem16_arbiter #(.ACCESS_CYCLES(AC1), .STARVE_LIMIT(SL)) dut1 (
    .clk(clk), .rst(rst),
    .f_req(f_req1), .f_addr(f_addr1), .f_ack(f_ack1), .f_rdata(f_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_ack(d_ack1), .d_rdata(d_rdata1),
    .mem_address(mem_address1), .mem_datain(mem_datain1),
    .mem_write_enable(mem_write_enable1), .mem_dataout(mem_dataout1)
`ifdef MEM16_ARB_STATS_EN
    , .stat_f_grants(), .stat_d_grants(), .stat_stall()
`endif
  );

  // Reference memory contents as seen by completed transactions.
  logic [15:0] shadow [2048];
  bit          sh_wr  [2048];

  function automatic logic [15:0] model_rd(input logic [10:0] a);
    return sh_wr[a] ? shadow[a] : init_val(a);
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        f;
    logic [10:0] fa;
    logic        d;
    logic        we;
    logic [10:0] da;
    logic [15:0] wd;
    logic        exp_d;
    logic [15:0] exp_rdata;
    int unsigned exp_we;
    logic [10:0] exp_addr;
  } vec_t;

  vec_t        vecs [8];
  logic        got_d, tail;
  int unsigned lat, we_cyc;
  logic [15:0] rdata;
  logic [10:0] addr1;
  logic        fo, dn, w, exp_first_d, served_f, served_d;
  logic [10:0] fa, da;
  logic [15:0] wd;
  int          consec, nack, nacks, last_cyc, k;
  logic [9:0]  order, exp_order;

  task automatic do_reset();
    rst   = 1'b1;
    f_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One transaction from IDLE; returns at the negedge where the arbiter is IDLE again.
  task automatic txn(input logic f, input logic [10:0] a_f, input logic d, input logic we,
                     input logic [10:0] a_d, input logic [15:0] wdat,
                     output logic o_d, output int unsigned o_lat, output int unsigned o_we,
                     output logic [15:0] o_rdata, output logic [10:0] o_addr1, output logic o_tail);
    f_req = f; f_addr = a_f; d_req = d; d_we = we; d_addr = a_d; d_wdata = wdat;
    o_d = 1'b0; o_lat = 0; o_we = 0; o_rdata = '0; o_addr1 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) o_addr1 = mem_address;
      if (mem_write_enable) o_we++;
      if (f_ack || d_ack) begin
        o_lat   = c;
        o_d     = d_ack;
        o_rdata = d_ack ? d_rdata : f_rdata;
        break;
      end
    end
    if (o_d && we) begin
      shadow[a_d] = wdat;
      sh_wr[a_d]  = 1'b1;
    end
    f_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    o_tail = f_ack | d_ack;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 11'd0,    1'b0, 1'b0, 11'd0,    16'h0000, 1'b0, init_val(11'd0),    0, 11'd0};
    vecs[1] = '{1'b0, 11'd0,    1'b1, 1'b1, 11'd5,    16'hA55A, 1'b1, 16'h0000,           2, 11'd5};
    vecs[2] = '{1'b0, 11'd0,    1'b1, 1'b0, 11'd5,    16'h0000, 1'b1, 16'hA55A,           0, 11'd5};
    vecs[3] = '{1'b1, 11'd2047, 1'b0, 1'b0, 11'd0,    16'h0000, 1'b0, init_val(11'd2047), 0, 11'd2047};
    vecs[4] = '{1'b1, 11'd7,    1'b1, 1'b0, 11'd9,    16'h0000, 1'b1, init_val(11'd9),    0, 11'd9};
    vecs[5] = '{1'b0, 11'd0,    1'b1, 1'b1, 11'd2047, 16'hFFFF, 1'b1, init_val(11'd9),    2, 11'd2047};
    vecs[6] = '{1'b0, 11'd0,    1'b1, 1'b0, 11'd2047, 16'h0000, 1'b1, 16'hFFFF,           0, 11'd2047};
    vecs[7] = '{1'b1, 11'd2047, 1'b0, 1'b0, 11'd0,    16'h0000, 1'b0, 16'hFFFF,           0, 11'd2047};

    rst = 1'b1;
    f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    f_req1 = 1'b0; f_addr1 = '0; d_req1 = 1'b0; d_we1 = 1'b0; d_addr1 = '0; d_wdata1 = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({f_ack, d_ack, f_rdata, d_rdata, mem_address, mem_datain, mem_write_enable}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      txn(vecs[i].f, vecs[i].fa, vecs[i].d, vecs[i].we, vecs[i].da, vecs[i].wd,
          got_d, lat, we_cyc, rdata, addr1, tail);
      check($sformatf("vec%0d_port", i),    64'(got_d),  64'(vecs[i].exp_d));
      check($sformatf("vec%0d_latency", i), 64'(lat),    64'(AC + 1));
      check($sformatf("vec%0d_rdata", i),   64'(rdata),  64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_we_cycles", i), 64'(we_cyc), 64'(vecs[i].exp_we));
      check($sformatf("vec%0d_address", i), 64'(addr1),  64'(vecs[i].exp_addr));
      check($sformatf("vec%0d_ack_pulse", i), 64'(tail), 64'd0);
    end

    // Reset during the first ACCESS cycle of a store.
    d_req = 1'b1; d_we = 1'b1; d_addr = 11'd20; d_wdata = 16'h1234;
    @(negedge clk);
    check("midrst_we_high", 64'(mem_write_enable), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_we_dropped", 64'(mem_write_enable), 64'd0);
    check("midrst_no_ack", 64'({f_ack, d_ack}), 64'd0);
    rst = 1'b0;
    txn(1'b0, 11'd0, 1'b1, 1'b1, 11'd20, 16'h1234, got_d, lat, we_cyc, rdata, addr1, tail);
    check("midrst_reserve_port", 64'(got_d), 64'd1);
    check("midrst_reserve_latency", 64'(lat), 64'(AC + 1));
    check("midrst_reserve_we_cycles", 64'(we_cyc), 64'(AC));
    txn(1'b0, 11'd0, 1'b1, 1'b0, 11'd20, 16'h0000, got_d, lat, we_cyc, rdata, addr1, tail);
    check("midrst_readback", 64'(rdata), 64'h1234);

    // Continuous contention: D wins SL times in a row over a waiting F, then F once.
    do_reset();
    f_req = 1'b1; f_addr = 11'd4; d_req = 1'b1; d_we = 1'b0; d_addr = 11'd3; d_wdata = '0;
    consec = 0; exp_order = '0; order = '0; nacks = 0; last_cyc = 0;
    for (int j = 0; j < 10; j++) begin
      if (consec == SL) begin
        exp_order[j] = 1'b0;
        consec = 0;
      end else begin
        exp_order[j] = 1'b1;
        consec++;
      end
    end
    for (int c = 1; c <= 120 && nacks < 10; c++) begin
      @(negedge clk);
      if (f_ack || d_ack) begin
        order[nacks] = d_ack;
        if (d_ack) check("cont_d_data", 64'(d_rdata), 64'(model_rd(11'd3)));
        else       check("cont_f_data", 64'(f_rdata), 64'(model_rd(11'd4)));
        nacks++;
        last_cyc = c;
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("cont_grant_order", 64'(order), 64'(exp_order));
    check("cont_last_ack_cycle", 64'(last_cyc), 64'((AC + 1) + 9 * (AC + 2)));

    // Randomized transactions against the transaction-level model.
    do_reset();
    consec = 0;
    for (int s = 0; s < 150; s++) begin
      do begin
        fo = 1'($urandom_range(0, 1));
        dn = 1'($urandom_range(0, 1));
      end while (!fo && !dn);
      fa = 11'($urandom_range(0, 15));
      da = 11'($urandom_range(0, 15));
      w  = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      f_req = fo; f_addr = fa; d_req = dn; d_we = w; d_addr = da; d_wdata = wd;
      exp_first_d = dn && !(fo && consec == SL);
      served_f = !fo; served_d = !dn; nack = 0;
      for (int c = 1; c <= 30 && !(served_f && served_d); c++) begin
        @(negedge clk);
        if (f_ack) begin
          check("rnd_f_data", 64'(f_rdata), 64'(model_rd(fa)));
          check("rnd_f_latency", 64'(c), 64'((nack == 0) ? AC + 1 : 2 * AC + 3));
          if (nack == 0) check("rnd_first_winner", 64'(1'b0), 64'(exp_first_d));
          consec = 0;
          nack++; served_f = 1'b1; f_req = 1'b0;
        end
        if (d_ack) begin
          if (w) begin
            shadow[da] = wd;
            sh_wr[da]  = 1'b1;
          end else begin
            check("rnd_d_data", 64'(d_rdata), 64'(model_rd(da)));
          end
          check("rnd_d_latency", 64'(c), 64'((nack == 0) ? AC + 1 : 2 * AC + 3));
          if (nack == 0) check("rnd_first_winner", 64'(1'b1), 64'(exp_first_d));
          if (fo && !served_f && consec < SL) consec++;
          nack++; served_d = 1'b1; d_req = 1'b0;
        end
      end
      check("rnd_all_served", 64'({served_f, served_d}), 64'(2'b11));
      f_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
    end

    // Back-to-back fetches on the single-cycle-access instance.
    f_req1 = 1'b1; f_addr1 = 11'd0; k = 0;
    for (int c = 1; c <= 40 && k < 3; c++) begin
      @(negedge clk);
      if (f_ack1) begin
        check("b2b_data", 64'(f_rdata1), 64'(init_val(11'(k))));
        check("b2b_ack_cycle", 64'(c), 64'((AC1 + 1) + k * (AC1 + 2)));
        k++;
        f_addr1 = 11'(k);
        if (k == 3) f_req1 = 1'b0;
      end
    end
    f_req1 = 1'b0;
    check("b2b_ack_count", 64'(k), 64'd3);
    check("b2b_d_port_idle", 64'({d_ack1, d_rdata1, mem_write_enable1}), 64'd0);

`ifdef MEM16_ARB_STATS_EN
    do_reset();
    txn(1'b1, 11'd1, 1'b0, 1'b0, 11'd0, 16'h0000, got_d, lat, we_cyc, rdata, addr1, tail);
    txn(1'b1, 11'd2, 1'b0, 1'b0, 11'd0, 16'h0000, got_d, lat, we_cyc, rdata, addr1, tail);
    txn(1'b1, 11'd3, 1'b0, 1'b0, 11'd0, 16'h0000, got_d, lat, we_cyc, rdata, addr1, tail);
    txn(1'b0, 11'd0, 1'b1, 1'b1, 11'd30, 16'h1111, got_d, lat, we_cyc, rdata, addr1, tail);
    txn(1'b0, 11'd0, 1'b1, 1'b1, 11'd31, 16'h2222, got_d, lat, we_cyc, rdata, addr1, tail);
    check("stat_f_grants", 64'(stat_f_grants), 64'd3);
    check("stat_d_grants", 64'(stat_d_grants), 64'd2);
    check("stat_stall", 64'(stat_stall), 64'(5 * (AC + 1)));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
